// File: rtl/lzw_code_packer.sv
`default_nettype none
// ============================================================================
//  Module      : lzw_code_packer
//  Description : Packs fixed-width LZW codes LSB-first (GIF-style) into a
//                continuous byte stream with valid/ready handshakes on both
//                sides. A flush request drains the partial final byte with
//                zero padding and then pulses FlushDone for one cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clock      in   1           single clock, all state updates on posedge
//    Reset_n    in   1           asynchronous active-low reset
//    CodeIn     in   CODE_WIDTH  code to pack
//    CodeValid  in   1           CodeIn valid this cycle
//    CodeReady  out  1           packer accepts a code this cycle
//    Flush      in   1           single-cycle request to drain pending bits
//    OutByte    out  8           packed output byte
//    OutValid   out  1           OutByte valid
//    OutReady   in   1           consumer takes OutByte this cycle
//    FlushDone  out  1           one-cycle pulse when a flush has completed
//    BitCount   out  5           pending bits in the accumulator
//    BytesOut   out  16          running count of emitted bytes (wraps)
//  The 5-bit BitCount limits ACC_WIDTH to at most 31.
// ============================================================================
module lzw_code_packer #(
   parameter int CODE_WIDTH = 12,
   parameter int ACC_WIDTH  = 2 * CODE_WIDTH
) (
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic [CODE_WIDTH-1:0] CodeIn,
   input  logic                  CodeValid,
   output logic                  CodeReady,
   input  logic                  Flush,
   output logic [7:0]            OutByte,
   output logic                  OutValid,
   input  logic                  OutReady,
   output logic                  FlushDone,
   output logic [4:0]            BitCount,
   output logic [15:0]           BytesOut
);

   localparam logic [4:0] C_CODE_W   = 5'(CODE_WIDTH);
   localparam logic [4:0] C_READY_MAX = 5'(ACC_WIDTH - CODE_WIDTH);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                 state_q,     state_d;
   logic [ACC_WIDTH-1:0]   acc_q,       acc_d;
   logic [4:0]             bit_count_q, bit_count_d;
   logic [15:0]            bytes_out_q, bytes_out_d;

   logic                   w_accept;
   logic                   w_emit;
   logic [ACC_WIDTH-1:0]   w_acc_base;
   logic [4:0]             w_cnt_base;
   logic [ACC_WIDTH-1:0]   w_code_ext;

   // Handshake-side outputs are pure functions of the registers.
   assign CodeReady = (state_q == ST_RUN) && (bit_count_q <= C_READY_MAX);
   assign OutValid  = (bit_count_q >= 5'd8) ||
                      ((state_q == ST_FLUSH) && (bit_count_q != 5'd0));
   assign OutByte   = acc_q[7:0];
   assign FlushDone = (state_q == ST_DONE);
   assign BitCount  = bit_count_q;
   assign BytesOut  = bytes_out_q;

   assign w_accept   = CodeValid && CodeReady;
   assign w_emit     = OutValid && OutReady;
   assign w_code_ext = ACC_WIDTH'(CodeIn);

   // Accumulator and counters. The byte removal is applied first; the
   // post-removal count is then the insertion point for a new code, which
   // covers accept-only, emit-only and the combined case uniformly. Because
   // bits above the count are always zero, a short final flush byte is
   // padded with zeros for free.
   always_comb begin
      w_acc_base  = acc_q;
      w_cnt_base  = bit_count_q;
      acc_d       = acc_q;
      bit_count_d = bit_count_q;
      bytes_out_d = bytes_out_q;

      if (w_emit) begin
         w_acc_base  = acc_q >> 8;
         w_cnt_base  = (bit_count_q >= 5'd8) ? (bit_count_q - 5'd8) : 5'd0;
         bytes_out_d = bytes_out_q + 16'd1;
      end

      acc_d       = w_acc_base;
      bit_count_d = w_cnt_base;

      if (w_accept) begin
         acc_d       = w_acc_base | (w_code_ext << w_cnt_base);
         bit_count_d = w_cnt_base + C_CODE_W;
      end
   end

   // Control FSM. A code accepted alongside Flush is packed by the datapath
   // above in the same cycle, so it is included in the drain.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (Flush) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (bit_count_q == 5'd0) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_RUN;
         acc_q       <= '0;
         bit_count_q <= 5'd0;
         bytes_out_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         bit_count_q <= bit_count_d;
         bytes_out_q <= bytes_out_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/lzw_code_packer.md
Name: lzw_code_packer

Overview:
- Downstream stage of the LZW register/datapath block: consumes the `Code` values that block emits and packs them into a continuous byte stream for the output RAM/UART writer.
- Codes are CODE_WIDTH bits wide and are packed LSB-first (GIF-style) into a bit accumulator.
- Bytes are emitted over a valid/ready handshake; a flush request drains the residual partial byte with zero padding and signals completion.

Parameters:
- CODE_WIDTH, 12, width of each input code (legal range 9..16).
- ACC_WIDTH, 2*CODE_WIDTH, bit-accumulator width; must be ≥ CODE_WIDTH+8.

Ports:
- Clock  in  1  single clock; all state updates on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- CodeIn  in  CODE_WIDTH  code to pack.
- CodeValid  in  1  CodeIn is valid this cycle.
- CodeReady  out  1  packer can accept a code this cycle.
- Flush  in  1  single-cycle request to drain all pending bits.
- OutByte  out  8  packed output byte.
- OutValid  out  1  OutByte is valid.
- OutReady  in  1  consumer takes OutByte this cycle.
- FlushDone  out  1  one-cycle pulse when a flush has completed.
- BitCount  out  5  number of pending bits in the accumulator (0..ACC_WIDTH).
- BytesOut  out  16  running count of emitted bytes; wraps 0xFFFF→0.

Behaviour:
- Reset (Reset_n=0, asynchronous) clears:
  - accumulator to 0 and BitCount to 0;
  - state to RUN;
  - BytesOut to 0 and FlushDone to 0.
  - Resulting outputs: OutValid=0 and CodeReady=1 once Reset_n is released. Reset mid-transfer drops all pending bits with no partial byte emitted.
- States:
  - RUN: normal packing.
  - FLUSH: draining the accumulator.
  - DONE: one cycle; FlushDone=1.
- Handshake events:
  - Code accept: CodeValid && CodeReady.
  - Byte emit: OutValid && OutReady.
  - Both may occur in the same cycle.
- CodeReady = (state==RUN) && (BitCount ≤ ACC_WIDTH−CODE_WIDTH), computed combinationally from registers. It does not depend on OutReady.
- OutValid = (BitCount ≥ 8) || (state==FLUSH && BitCount > 0).
- OutByte = accumulator[7:0]. Bits above BitCount are guaranteed 0, so the last flush byte is zero-padded.
- Accumulator update per cycle; let c = BitCount:
  - emit only: acc ← acc>>8; BitCount ← c − min(8,c).
  - accept only: acc ← acc | (CodeIn << c); BitCount ← c + CODE_WIDTH.
  - both: acc ← (acc>>8) | (CodeIn << (c−8)); BitCount ← c − 8 + CODE_WIDTH. Emit-with-accept only occurs in RUN, so c ≥ 8 holds.
- Each emit increments BytesOut by 1, modulo 2^16.
- RUN→FLUSH transition:
  - Taken on Flush=1.
  - A code accepted in the same cycle as Flush is packed before the flush takes effect.
  - Flush is ignored in FLUSH and DONE.
- FLUSH behaviour:
  - CodeReady=0; emit bytes until BitCount==0.
  - Go to DONE on the cycle after BitCount reaches 0.
  - If BitCount==0 on entry, go to DONE on the next cycle.
- DONE: FlushDone=1 for exactly one cycle, CodeReady=0; then return to RUN.
- OutByte/OutValid must hold stable while OutValid=1 && OutReady=0.
- Latency: a code accepted at cycle t makes its first byte visible at t+1, provided BitCount ≥ 8 after the update.
- Max occupancy: BitCount never exceeds ACC_WIDTH (24 at default). With OutReady held low, at most two codes are accepted.

Test Plan:
- Basic packing: OutReady=1, codes 0x041 then 0x042 → OutByte sequence 0x41, 0x20, 0x04; BitCount ends at 0; BytesOut=3.
- Flush of partial byte: code 0xABC, then Flush → bytes 0xBC, 0x0A (zero-padded). FlushDone pulses exactly 1 cycle after BitCount hits 0; state returns to RUN; CodeReady=1.
- Backpressure: OutReady=0, CodeValid=1 continuously → codes accepted at 2 cycles only (BitCount 12, then 24), then CodeReady=0. OutByte is held at the first byte. Raising OutReady drains 3 bytes, and CodeReady reasserts when BitCount ≤ 12.
- Simultaneous accept+emit: BitCount=12 holding code 0x123, OutReady=1, accept 0x456 → emitted 0x23; BitCount=16; next bytes 0x61, 0x45.
- Flush with code same cycle, and empty flush:
  - Flush with CodeValid=1, code 0x0FF, BitCount=0 → 0xFF, 0x00 emitted, then FlushDone.
  - Flush at BitCount=0 with no code → no bytes; FlushDone 2 cycles later.
- Async reset mid-stream: assert Reset_n=0 between clock edges with BitCount=20 → BitCount=0, OutValid=0, BytesOut=0 immediately, without waiting for a clock edge. After release, a fresh code 0x001 produces 0x01 as the first byte.
